log_bank_sequencer: RTL and testbench

LOG_BANK_SEQUENCER -- requirements
Module: log_bank_sequencer

---
 rtl/log_bank_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_log_bank_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_bank_sequencer.sv
// log_bank_sequencer: walks NUM_BANDS filterbank energies through an external
// log2 unit and writes the results to a result buffer in ascending order.
// Zero energies bypass the log unit; a stalled conversion aborts the frame.
module log_bank_sequencer #(
    parameter int unsigned NUM_BANDS = 24,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        en_rd,
    output logic [4:0]  en_rd_addr,
    input  logic [63:0] en_rd_data,
    output logic        log_start,
    output logic [63:0] log_indata,
    input  logic [20:0] log_outdata,
    input  logic        log_dv,
    output logic        res_wr,
    output logic [4:0]  res_addr,
    output logic [20:0] res_data
);

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned EN_W   = 64;
    localparam int unsigned RES_W  = 21;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_BANDS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_CONVERT = 3'd3,
        S_WRITE   = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_en_rd;
    logic [IDX_W-1:0]   r_en_rd_addr;
    logic               r_log_start;
    logic [EN_W-1:0]    r_log_indata;
    logic               r_res_wr;
    logic [IDX_W-1:0]   r_res_addr;
    logic [RES_W-1:0]   r_res_data;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic               w_en_rd_nxt;
    logic [IDX_W-1:0]   w_en_rd_addr_nxt;
    logic               w_log_start_nxt;
    logic [EN_W-1:0]    w_log_indata_nxt;
    logic               w_res_wr_nxt;
    logic [IDX_W-1:0]   w_res_addr_nxt;
    logic [RES_W-1:0]   w_res_data_nxt;

    // State and registered outputs; synchronous active-low reset clears everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_en_rd      <= 1'b0;
            r_en_rd_addr <= '0;
            r_log_start  <= 1'b0;
            r_log_indata <= '0;
            r_res_wr     <= 1'b0;
            r_res_addr   <= '0;
            r_res_data   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_en_rd      <= w_en_rd_nxt;
            r_en_rd_addr <= w_en_rd_addr_nxt;
            r_log_start  <= w_log_start_nxt;
            r_log_indata <= w_log_indata_nxt;
            r_res_wr     <= w_res_wr_nxt;
            r_res_addr   <= w_res_addr_nxt;
            r_res_data   <= w_res_data_nxt;
        end
    end

    // Next state and next output values; strobes default low, held values default to current
    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_cnt_nxt        = r_cnt;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_err_nxt        = r_err;
        w_en_rd_nxt      = 1'b0;
        w_en_rd_addr_nxt = r_en_rd_addr;
        w_log_start_nxt  = r_log_start;
        w_log_indata_nxt = r_log_indata;
        w_res_wr_nxt     = 1'b0;
        w_res_addr_nxt   = r_res_addr;
        w_res_data_nxt   = r_res_data;

        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_state_nxt      = S_READ;
                    w_idx_nxt        = '0;
                    w_err_nxt        = 1'b0;
                    w_busy_nxt       = 1'b1;
                    w_en_rd_nxt      = 1'b1;
                    w_en_rd_addr_nxt = '0;
                end
            end
            S_READ: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (en_rd_data != '0) begin
                    w_state_nxt      = S_CONVERT;
                    w_cnt_nxt        = '0;
                    w_log_start_nxt  = 1'b1;
                    w_log_indata_nxt = en_rd_data;
                end else begin
                    // log of zero is undefined; write 0 without touching the log unit
                    w_state_nxt    = S_WRITE;
                    w_res_wr_nxt   = 1'b1;
                    w_res_addr_nxt = r_idx;
                    w_res_data_nxt = '0;
                end
            end
            S_CONVERT: begin
                if (log_dv) begin
                    w_state_nxt     = S_WRITE;
                    w_log_start_nxt = 1'b0;
                    w_res_wr_nxt    = 1'b1;
                    w_res_addr_nxt  = r_idx;
                    w_res_data_nxt  = log_outdata;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt     = S_FINISH;
                    w_log_start_nxt = 1'b0;
                    w_err_nxt       = 1'b1;
                    w_done_nxt      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_FINISH;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt      = S_READ;
                    w_idx_nxt        = r_idx + IDX_W'(1);
                    w_en_rd_nxt      = 1'b1;
                    w_en_rd_addr_nxt = r_idx + IDX_W'(1);
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign en_rd      = r_en_rd;
    assign en_rd_addr = r_en_rd_addr;
    assign log_start  = r_log_start;
    assign log_indata = r_log_indata;
    assign res_wr     = r_res_wr;
    assign res_addr   = r_res_addr;
    assign res_data   = r_res_data;

endmodule

// File: tb/tb_log_bank_sequencer.sv
// Bench for log_bank_sequencer: energy buffer and log2 stub models, a
// frame-level reference that predicts writes, err and busy duration, and
// directed plus randomized frames.
module tb_log_bank_sequencer;

    localparam int unsigned NB = 4;
    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        busy;
    logic        done;
    logic        err;
    logic        en_rd;
    logic [4:0]  en_rd_addr;
    logic [63:0] en_rd_data = '0;
    logic        log_start;
    logic [63:0] log_indata;
    logic [20:0] log_outdata;
    logic        log_dv;
    logic        res_wr;
    logic [4:0]  res_addr;
    logic [20:0] res_data;

    log_bank_sequencer #(
        .NUM_BANDS (NB),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .en_rd       (en_rd),
        .en_rd_addr  (en_rd_addr),
        .en_rd_data  (en_rd_data),
        .log_start   (log_start),
        .log_indata  (log_indata),
        .log_outdata (log_outdata),
        .log_dv      (log_dv),
        .res_wr      (res_wr),
        .res_addr    (res_addr),
        .res_data    (res_data)
    );

    always #5 clk = ~clk;

    // Stimulus tables: energy per band and stub delay per band (0 = never answers)
    logic [63:0] en_mem [NB];
    int          band_dly [NB];
    int          cur_band = 0;
    logic        spur_en = 1'b0;
    logic        spur_dv = 1'b0;
    int          stub_cnt = 0;
    logic        stub_dv = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0]  got_addr [$];
    logic [20:0] got_data [$];
    logic [4:0]  exp_addr [$];
    logic [20:0] exp_data [$];
    int          n_done;
    int          n_busy;
    int          n_zero_start;
    int          exp_busy;
    logic        exp_err;

    // Energy buffer: one-cycle read latency
    always @(posedge clk) begin
        if (en_rd) en_rd_data <= en_mem[en_rd_addr[1:0]];
    end

    // Log2 stub: answers indata[20:0], dv pulse band_dly cycles after start is seen
    always @(posedge clk) begin
        if (!log_start) begin
            stub_cnt <= 0;
            stub_dv  <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            stub_dv  <= (band_dly[cur_band] != 0) && (stub_cnt + 1 == band_dly[cur_band]);
        end
    end

    assign log_outdata = log_indata[20:0];
    assign log_dv      = stub_dv | spur_dv;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock; all DUT sampling happens here on the falling edge
    task automatic tick();
        @(negedge clk);
        if (res_wr) begin
            got_addr.push_back(res_addr);
            got_data.push_back(res_data);
        end
        if (done) n_done++;
        if (busy) n_busy++;
        if (log_start && log_indata == '0) n_zero_start++;
        if (en_rd) cur_band = int'(en_rd_addr);
        spur_dv = spur_en && en_rd;
    endtask

    // Frame reference: per-band outcome from the energy/delay tables
    task automatic build_expect();
        int d;
        exp_addr.delete();
        exp_data.delete();
        exp_busy = 0;
        exp_err  = 1'b0;
        for (int i = 0; i < int'(NB); i++) begin
            if (en_mem[i] == 64'd0) begin
                exp_addr.push_back(5'(i));
                exp_data.push_back(21'd0);
                exp_busy += 3;
            end else begin
                d = band_dly[i] + 1;
                if (band_dly[i] == 0 || d > int'(TO)) begin
                    exp_err = 1'b1;
                    exp_busy += 2 + int'(TO);
                    break;
                end
                exp_addr.push_back(5'(i));
                exp_data.push_back(en_mem[i][20:0]);
                exp_busy += 3 + d;
            end
        end
        exp_busy += 1;
    endtask

    task automatic run_frame(input string tag, input bit spur, input int go_at, input bit go_fin);
        int cyc;
        int n;
        build_expect();
        got_addr.delete();
        got_data.delete();
        n_done = 0;
        n_busy = 0;
        n_zero_start = 0;
        spur_en = spur;
        go = 1'b1;
        tick();
        go = 1'b0;
        check_val({tag, ":start_busy"}, 64'(busy), 64'd1);
        check_val({tag, ":err_clr"}, 64'(err), 64'd0);
        check_val({tag, ":rd0"}, 64'({en_rd, en_rd_addr}), 64'({1'b1, 5'd0}));
        cyc = 1;
        while (n_done == 0 && cyc < 2000) begin
            go = (cyc == go_at);
            tick();
            cyc++;
        end
        go = go_fin;
        tick();
        go = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        spur_en = 1'b0;
        check_val({tag, ":done_cnt"}, 64'(n_done), 64'd1);
        check_val({tag, ":err"}, 64'(err), 64'(exp_err));
        check_val({tag, ":busy_after"}, 64'(busy), 64'd0);
        check_val({tag, ":busy_cycles"}, 64'(n_busy), 64'(exp_busy));
        check_val({tag, ":zero_start"}, 64'(n_zero_start), 64'd0);
        check_val({tag, ":n_writes"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s:addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
            check_val($sformatf("%s:data%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
        end
    endtask

    initial begin
        int n_pre;
        int cyc;
        int go_at;
        rst_n = 1'b0;
        go    = 1'b0;
        for (int i = 0; i < int'(NB); i++) begin
            en_mem[i]   = '0;
            band_dly[i] = 1;
        end
        tick();
        tick();
        check_val("rst:ctrl", 64'({busy, done, err, en_rd, log_start, res_wr}), 64'd0);
        check_val("rst:addr", 64'({en_rd_addr, res_addr}), 64'd0);
        check_val("rst:indata", log_indata, 64'd0);
        check_val("rst:resdata", 64'(res_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame, stub answers 10 cycles after start
        en_mem[0] = 64'd548674; en_mem[1] = 64'd1; en_mem[2] = 64'd1024; en_mem[3] = 64'd7;
        for (int i = 0; i < int'(NB); i++) band_dly[i] = 9;
        run_frame("basic", 1'b0, -1, 1'b0);

        // Zero energy at band 2 bypasses the log unit
        en_mem[2] = 64'd0;
        run_frame("zero2", 1'b0, -1, 1'b0);

        // Stub never answers band 1: timeout abort
        en_mem[2] = 64'd1024;
        band_dly[1] = 0;
        run_frame("timeout", 1'b0, -1, 1'b0);

        // Answer on the last allowed CONVERT cycle is still accepted
        band_dly[1] = int'(TO) - 1;
        run_frame("dv_at_limit", 1'b0, -1, 1'b0);

        // go while busy, spurious dv in READ, go during FINISH: all ignored
        band_dly[1] = 4;
        run_frame("ignore", 1'b1, 6, 1'b1);

        // Reset during the first CONVERT cycle of band 1
        en_mem[0] = 64'd0;
        en_mem[1] = 64'h1_2345_6789;
        band_dly[1] = 10;
        got_addr.delete();
        got_data.delete();
        go = 1'b1;
        tick();
        go = 1'b0;
        cyc = 0;
        while (!(log_start && cur_band == 1) && cyc < 200) begin
            tick();
            cyc++;
        end
        check_val("rstmid:reached", 64'(log_start), 64'd1);
        n_pre = got_addr.size();
        rst_n = 1'b0;
        tick();
        check_val("rstmid:ctrl", 64'({busy, done, err, en_rd, log_start, res_wr}), 64'd0);
        check_val("rstmid:addr", 64'({en_rd_addr, res_addr}), 64'd0);
        check_val("rstmid:indata", log_indata, 64'd0);
        check_val("rstmid:resdata", 64'(res_data), 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check_val("rstmid:pre_writes", 64'(n_pre), 64'd1);
        check_val("rstmid:no_more_writes", 64'(got_addr.size()), 64'(n_pre));
        run_frame("after_rst", 1'b0, -1, 1'b0);

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < int'(NB); i++) begin
                if ($urandom_range(3) == 0) en_mem[i] = '0;
                else en_mem[i] = {$urandom, $urandom} >> $urandom_range(63);
                band_dly[i] = ($urandom_range(19) == 0) ? 0 : int'($urandom_range(12, 1));
            end
            go_at = ($urandom_range(1) == 1) ? int'($urandom_range(10, 2)) : -1;
            run_frame($sformatf("rnd%0d", f), 1'($urandom_range(1)), go_at, 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
